// File: rtl/mem_stage_hs.sv
// mem_stage_hs: handshaked memory stage with req/ack data memory, jump-flag file and registered PC redirect
module mem_stage_hs #(
   parameter int DATA_WIDTH      = 32,
   parameter int PC_WIDTH        = 32,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int FLAG_COUNT      = 6,
   parameter int FLAG_CODE_WIDTH = 5,
   parameter int ZERO_IDX        = 0,
   parameter int TRUE_IDX        = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_mem_read,
   input  logic                       in_mem_write,
   input  logic                       in_is_branch,
   input  logic                       in_is_jump,
   input  logic                       in_sel_beq_bne,
   input  logic                       in_sel_jflag_branch,
   input  logic                       in_fl_write_enable,
   input  logic                       in_sel_jt_jf,
   input  logic                       in_reg_write_enable,
   input  logic [1:0]                 in_wb_res_mux,
   input  logic [PC_WIDTH-1:0]        in_next_pc,
   input  logic [PC_WIDTH-1:0]        in_branch_addr,
   input  logic [PC_WIDTH-1:0]        in_abs_addr,
   input  logic [DATA_WIDTH-1:0]      in_mem_addr,
   input  logic [DATA_WIDTH-1:0]      in_mem_data,
   input  logic [DATA_WIDTH-1:0]      in_alu_res,
   input  logic [DATA_WIDTH-1:0]      in_immediate,
   input  logic [FLAG_COUNT-1:0]      in_alu_flags,
   input  logic [FLAG_CODE_WIDTH-1:0] in_flag_code,
   input  logic [REG_ADDR_WIDTH-1:0]  in_reg_dst,
   output logic                       dmem_req,
   output logic                       dmem_we,
   output logic [DATA_WIDTH-1:0]      dmem_addr,
   output logic [DATA_WIDTH-1:0]      dmem_wdata,
   input  logic                       dmem_ack,
   input  logic [DATA_WIDTH-1:0]      dmem_rdata,
   output logic                       out_valid,
   output logic                       out_reg_write_enable,
   output logic [1:0]                 out_wb_res_mux,
   output logic [REG_ADDR_WIDTH-1:0]  out_reg_dst,
   output logic [PC_WIDTH-1:0]        out_next_pc,
   output logic [DATA_WIDTH-1:0]      out_mem_data,
   output logic [DATA_WIDTH-1:0]      out_alu_res,
   output logic [DATA_WIDTH-1:0]      out_imm,
   output logic                       out_redirect,
   output logic [PC_WIDTH-1:0]        out_redirect_addr
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                      state_q, state_d;
   logic [FLAG_COUNT-1:0]       flag_q, flag_d;
   logic                        we_q, we_d;
   logic [DATA_WIDTH-1:0]       addr_q, addr_d;
   logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
   logic                        pend_rwe_q, pend_rwe_d;
   logic                        pend_redir_q, pend_redir_d;
   logic                        ov_q, ov_d;
   logic                        orwe_q, orwe_d;
   logic                        ored_q, ored_d;
   logic [1:0]                  mux_q, mux_d;
   logic [REG_ADDR_WIDTH-1:0]   dst_q, dst_d;
   logic [PC_WIDTH-1:0]         npc_q, npc_d;
   logic [DATA_WIDTH-1:0]       mdata_q, mdata_d;
   logic [DATA_WIDTH-1:0]       alu_q, alu_d;
   logic [DATA_WIDTH-1:0]       imm_q, imm_d;
   logic [PC_WIDTH-1:0]         raddr_q, raddr_d;
   logic                        flag_bit, jt_jf_ok, beq_bne_ok, redir, accept, mem_op;

   assign in_ready   = (state_q == S_IDLE);
   assign accept     = in_valid & in_ready;
   assign mem_op     = in_mem_read | in_mem_write;
   assign jt_jf_ok   = in_sel_jt_jf ? ~flag_bit : flag_bit;
   assign beq_bne_ok = in_sel_beq_bne ? in_alu_flags[TRUE_IDX] : in_alu_flags[ZERO_IDX];
   assign redir      = in_is_jump | (in_is_branch & (in_sel_jflag_branch ? beq_bne_ok : jt_jf_ok));

   // pre-write stored flag selected by code; codes beyond the file read as zero
   always_comb begin
      flag_bit = 1'b0;
      for (int i = 0; i < FLAG_COUNT; i++)
         if (in_flag_code == FLAG_CODE_WIDTH'(i)) flag_bit = flag_q[i];
   end

   // next-state: accept in IDLE, wait for ack in WAIT; control outputs pulse for one cycle
   always_comb begin
      state_d      = state_q;
      flag_d       = flag_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      pend_rwe_d   = pend_rwe_q;
      pend_redir_d = pend_redir_q;
      ov_d         = 1'b0;
      orwe_d       = 1'b0;
      ored_d       = 1'b0;
      mux_d        = mux_q;
      dst_d        = dst_q;
      npc_d        = npc_q;
      mdata_d      = mdata_q;
      alu_d        = alu_q;
      imm_d        = imm_q;
      raddr_d      = raddr_q;
      if (accept) begin
         flag_d  = in_fl_write_enable ? in_alu_flags : flag_q;
         mux_d   = in_wb_res_mux;
         dst_d   = in_reg_dst;
         npc_d   = in_next_pc;
         alu_d   = in_alu_res;
         imm_d   = in_immediate;
         raddr_d = in_is_jump ? in_abs_addr : in_branch_addr;
         if (mem_op) begin
            state_d      = S_WAIT;
            we_d         = in_mem_write;
            addr_d       = in_mem_addr;
            wdata_d      = in_mem_data;
            pend_rwe_d   = in_reg_write_enable;
            pend_redir_d = redir;
         end else begin
            ov_d    = 1'b1;
            orwe_d  = in_reg_write_enable;
            ored_d  = redir;
            mdata_d = '0;
         end
      end else if (state_q == S_WAIT && dmem_ack) begin
         state_d = S_IDLE;
         ov_d    = 1'b1;
         orwe_d  = pend_rwe_q;
         ored_d  = pend_redir_q;
         mdata_d = we_q ? '0 : dmem_rdata;
      end
   end

   // state registers with synchronous active-low reset clearing everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         flag_q       <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         pend_rwe_q   <= 1'b0;
         pend_redir_q <= 1'b0;
         ov_q         <= 1'b0;
         orwe_q       <= 1'b0;
         ored_q       <= 1'b0;
         mux_q        <= '0;
         dst_q        <= '0;
         npc_q        <= '0;
         mdata_q      <= '0;
         alu_q        <= '0;
         imm_q        <= '0;
         raddr_q      <= '0;
      end else begin
         state_q      <= state_d;
         flag_q       <= flag_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         pend_rwe_q   <= pend_rwe_d;
         pend_redir_q <= pend_redir_d;
         ov_q         <= ov_d;
         orwe_q       <= orwe_d;
         ored_q       <= ored_d;
         mux_q        <= mux_d;
         dst_q        <= dst_d;
         npc_q        <= npc_d;
         mdata_q      <= mdata_d;
         alu_q        <= alu_d;
         imm_q        <= imm_d;
         raddr_q      <= raddr_d;
      end
   end

   assign dmem_req             = (state_q == S_WAIT);
   assign dmem_we              = we_q;
   assign dmem_addr            = addr_q;
   assign dmem_wdata           = wdata_q;
   assign out_valid            = ov_q;
   assign out_reg_write_enable = orwe_q;
   assign out_redirect         = ored_q;
   assign out_wb_res_mux       = mux_q;
   assign out_reg_dst          = dst_q;
   assign out_next_pc          = npc_q;
   assign out_mem_data         = mdata_q;
   assign out_alu_res          = alu_q;
   assign out_imm              = imm_q;
   assign out_redirect_addr    = raddr_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: scoreboard bench for mem_stage_hs with directed and random instructions
module tb_mem_stage_hs;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic        in_mem_read = 1'b0, in_mem_write = 1'b0, in_is_branch = 1'b0, in_is_jump = 1'b0;
   logic        in_sel_beq_bne = 1'b0, in_sel_jflag_branch = 1'b0, in_fl_write_enable = 1'b0, in_sel_jt_jf = 1'b0;
   logic        in_reg_write_enable = 1'b0;
   logic [1:0]  in_wb_res_mux = '0;
   logic [31:0] in_next_pc = '0, in_branch_addr = '0, in_abs_addr = '0;
   logic [31:0] in_mem_addr = '0, in_mem_data = '0, in_alu_res = '0, in_immediate = '0;
   logic [5:0]  in_alu_flags = '0;
   logic [4:0]  in_flag_code = '0, in_reg_dst = '0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic        out_valid, out_reg_write_enable, out_redirect;
   logic [1:0]  out_wb_res_mux;
   logic [4:0]  out_reg_dst;
   logic [31:0] out_next_pc, out_mem_data, out_alu_res, out_imm, out_redirect_addr;

   typedef struct packed {
      logic        rd, wr, br, jmp, beq_bne, jfb, flwe, jtjf, rwe;
      logic [1:0]  mux;
      logic [31:0] npc, baddr, aaddr, maddr, mdata, alu, imm;
      logic [5:0]  fl;
      logic [4:0]  code, dst;
   } instr_t;

   typedef struct packed {
      logic        rwe, memop, redir;
      logic [1:0]  mux;
      logic [4:0]  dst;
      logic [31:0] npc, alu, imm, mdata, raddr;
   } exp_t;

   exp_t       q[$];
   exp_t       me;
   logic [5:0] flags_m = '0;
   int         checks = 0;
   int         errors = 0;
   instr_t     t;

   mem_stage_hs dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_is_branch(in_is_branch), .in_is_jump(in_is_jump),
      .in_sel_beq_bne(in_sel_beq_bne), .in_sel_jflag_branch(in_sel_jflag_branch),
      .in_fl_write_enable(in_fl_write_enable), .in_sel_jt_jf(in_sel_jt_jf),
      .in_reg_write_enable(in_reg_write_enable), .in_wb_res_mux(in_wb_res_mux),
      .in_next_pc(in_next_pc), .in_branch_addr(in_branch_addr), .in_abs_addr(in_abs_addr),
      .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data), .in_alu_res(in_alu_res),
      .in_immediate(in_immediate), .in_alu_flags(in_alu_flags), .in_flag_code(in_flag_code),
      .in_reg_dst(in_reg_dst), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .out_valid(out_valid), .out_reg_write_enable(out_reg_write_enable),
      .out_wb_res_mux(out_wb_res_mux), .out_reg_dst(out_reg_dst), .out_next_pc(out_next_pc),
      .out_mem_data(out_mem_data), .out_alu_res(out_alu_res), .out_imm(out_imm),
      .out_redirect(out_redirect), .out_redirect_addr(out_redirect_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
      end
   endtask

   function automatic instr_t rand_instr();
      instr_t r;
      int     k;
      r = '0;
      k = $urandom_range(0, 5);
      r.rd = (k == 0) || (k == 2);
      r.wr = (k == 1) || (k == 2);
      r.br = $urandom_range(0, 1) == 1;
      r.jmp = $urandom_range(0, 3) == 0;
      r.beq_bne = $urandom_range(0, 1) == 1;
      r.jfb = $urandom_range(0, 1) == 1;
      r.flwe = $urandom_range(0, 2) == 0;
      r.jtjf = $urandom_range(0, 1) == 1;
      r.rwe = $urandom_range(0, 1) == 1;
      r.mux = 2'($urandom_range(0, 3));
      r.npc = $urandom; r.baddr = $urandom; r.aaddr = $urandom;
      r.maddr = $urandom; r.mdata = $urandom; r.alu = $urandom; r.imm = $urandom;
      r.fl = 6'($urandom);
      r.code = 5'($urandom_range(0, 8));
      r.dst = 5'($urandom);
      return r;
   endfunction

   task automatic drive(input instr_t i);
      in_mem_read = i.rd; in_mem_write = i.wr; in_is_branch = i.br; in_is_jump = i.jmp;
      in_sel_beq_bne = i.beq_bne; in_sel_jflag_branch = i.jfb; in_fl_write_enable = i.flwe;
      in_sel_jt_jf = i.jtjf; in_reg_write_enable = i.rwe; in_wb_res_mux = i.mux;
      in_next_pc = i.npc; in_branch_addr = i.baddr; in_abs_addr = i.aaddr;
      in_mem_addr = i.maddr; in_mem_data = i.mdata; in_alu_res = i.alu; in_immediate = i.imm;
      in_alu_flags = i.fl; in_flag_code = i.code; in_reg_dst = i.dst;
   endtask

   // issue one instruction, push its expected retirement, and play the memory for loads/stores
   task automatic issue(input instr_t i, input int lat, input logic [31:0] rdv);
      exp_t e;
      logic fb, cond;
      chk("in_ready_idle", in_ready, 1);
      drive(i);
      in_valid = 1'b1;
      fb = 1'b0;
      if (i.code < 5'd6) fb = flags_m[i.code[2:0]];
      if (i.jtjf) fb = ~fb;
      cond = i.jfb ? (i.beq_bne ? i.fl[1] : i.fl[0]) : fb;
      e.rwe = i.rwe; e.memop = i.rd | i.wr; e.redir = i.jmp | (i.br & cond);
      e.mux = i.mux; e.dst = i.dst; e.npc = i.npc; e.alu = i.alu; e.imm = i.imm;
      e.mdata = i.wr ? 32'h0 : rdv;
      e.raddr = i.jmp ? i.aaddr : i.baddr;
      q.push_back(e);
      if (i.flwe) flags_m = i.fl;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i.rd | i.wr) begin
         for (int k = 0; k < lat; k++) begin
            chk("dmem_req", dmem_req, 1);
            chk("in_ready_wait", in_ready, 0);
            chk("dmem_we", dmem_we, i.wr);
            chk("dmem_addr", dmem_addr, i.maddr);
            if (i.wr) chk("dmem_wdata", dmem_wdata, i.mdata);
            dmem_rdata = rdv;
            dmem_ack = (k == lat - 1);
            @(posedge clk); #1;
         end
         dmem_ack = 1'b0;
         dmem_rdata = $urandom;
      end
      chk("out_valid_pulse", out_valid, 1);
   endtask

   // monitor: pop and compare on each retirement, control outputs must be quiet otherwise
   always @(negedge clk) begin
      if (out_valid) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
         end else begin
            me = q.pop_front();
            chk("out_reg_write_enable", out_reg_write_enable, me.rwe);
            chk("out_wb_res_mux", out_wb_res_mux, me.mux);
            chk("out_reg_dst", out_reg_dst, me.dst);
            chk("out_next_pc", out_next_pc, me.npc);
            chk("out_alu_res", out_alu_res, me.alu);
            chk("out_imm", out_imm, me.imm);
            if (me.memop) chk("out_mem_data", out_mem_data, me.mdata);
            chk("out_redirect", out_redirect, me.redir);
            chk("out_redirect_addr", out_redirect_addr, me.raddr);
         end
      end else begin
         chk("redirect_quiet", out_redirect, 0);
         chk("rwe_quiet", out_reg_write_enable, 0);
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_alu_res", out_alu_res, 0);
      chk("rst_out_redirect_addr", out_redirect_addr, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      t = '0; t.alu = 32'h1234; t.dst = 5'd7; t.rwe = 1'b1;
      issue(t, 0, 0);
      t = '0; t.rd = 1'b1; t.maddr = 32'h40; t.dst = 5'd3; t.rwe = 1'b1;
      issue(t, 3, 32'hDEADBEEF);
      t = '0; t.flwe = 1'b1; t.fl = 6'b000100;
      issue(t, 0, 0);
      t = '0; t.br = 1'b1; t.code = 5'd2; t.baddr = 32'h200; t.aaddr = 32'h300;
      issue(t, 0, 0);
      t.jtjf = 1'b1;
      issue(t, 0, 0);
      t.jtjf = 1'b0; t.code = 5'd9;
      issue(t, 0, 0);
      t = '0; t.br = 1'b1; t.jfb = 1'b1; t.fl = 6'b000001; t.baddr = 32'h44;
      issue(t, 0, 0);
      t = '0; t.br = 1'b1; t.jfb = 1'b1; t.beq_bne = 1'b1; t.fl = 6'b111101; t.baddr = 32'h48;
      issue(t, 0, 0);
      t = '0; t.jmp = 1'b1; t.aaddr = 32'h80; t.baddr = 32'h90;
      issue(t, 0, 0);
      t = '0; t.flwe = 1'b1; t.fl = 6'b000100;
      issue(t, 0, 0);
      t = '0; t.wr = 1'b1; t.maddr = 32'h88; t.mdata = 32'h55AA;
      drive(t);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("store_req", dmem_req, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      flags_m = '0;
      chk("rst_mid_req", dmem_req, 0);
      chk("rst_mid_ready", in_ready, 1);
      chk("rst_mid_we", dmem_we, 0);
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("late_ack_valid", out_valid, 0);
      chk("late_ack_req", dmem_req, 0);
      chk("late_ack_ready", in_ready, 1);
      t = '0; t.br = 1'b1; t.code = 5'd2; t.baddr = 32'h400;
      issue(t, 0, 0);
      for (int n = 0; n < 4; n++) begin
         t = '0; t.alu = 32'(n + 100); t.dst = 5'(n + 1); t.rwe = 1'b1;
         issue(t, 0, 0);
      end
      for (int n = 0; n < 300; n++) issue(rand_instr(), $urandom_range(1, 4), $urandom);
      drive('0);
      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
